cbus_rr_arbiter: RTL and testbench

Round-robin arbiter sharing one CBus slave port among NUM_INPUTS CBus masters (I-cache, D-cache, uncached path, ...). It replaces fixed-priority, one-cycle-latency arbitration with zero-added-latency grant and fair rotation. A transaction stays locked to its owner until the final response beat. Watchdog and protocol-error flags are provided for debug.

---
 rtl/cbus_pkg.sv | 20 ++
 rtl/cbus_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_pkg.sv
// rtl/cbus_pkg.sv - CBus request/response types shared by masters, slaves and the arbiter
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_rr_arbiter.sv
// rtl/cbus_rr_arbiter.sv - zero-latency round-robin CBus arbiter with per-transaction lock
module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int  NUM_INPUTS     = 4,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int IDX_W          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  cbus_req_t         ireqs  [NUM_INPUTS],
    output cbus_resp_t        iresps [NUM_INPUTS],
    output cbus_req_t         oreq,
    input  cbus_resp_t        oresp,
    output logic              busy,
    output logic [IDX_W-1:0]  owner,
    output logic              err_timeout,
    output logic              err_drop
);

    localparam int                WDOG_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_INPUTS - 1);
    localparam logic [IDX_W:0]    NUM_WIDE   = (IDX_W + 1)'(NUM_INPUTS);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);
    localparam logic [0:0]        ST_IDLE    = 1'b0;
    localparam logic [0:0]        ST_LOCKED  = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  cur;
    logic              any_valid;
    logic              grant;
    logic [WDOG_W-1:0] wdog;
    logic              err_timeout_q;
    logic              err_drop_q;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    // Scan downward from ptr+N-1 so the lowest offset from ptr with valid wins.
    always_comb begin
        logic [IDX_W:0] cand;
        cand      = '0;
        sel       = ptr;
        any_valid = 1'b0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= NUM_WIDE) begin
                cand = cand - NUM_WIDE;
            end
            if (ireqs[cand[IDX_W-1:0]].valid) begin
                sel       = cand[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign grant = (state == ST_LOCKED) || any_valid;
    assign cur   = (state == ST_LOCKED) ? owner_q : sel;

    always_comb begin
        oreq = '0;
        if (grant) begin
            oreq = ireqs[cur];
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = (grant && (cur == IDX_W'(i))) ? oresp : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            owner_q       <= '0;
            wdog          <= '0;
            err_timeout_q <= 1'b0;
            err_drop_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        owner_q <= sel;
                        if (oresp.last) begin
                            ptr <= next_idx(sel);
                        end else begin
                            state <= ST_LOCKED;
                            wdog  <= WDOG_W'(1);
                        end
                    end
                end
                default: begin
                    if (!ireqs[owner_q].valid) begin
                        err_drop_q <= 1'b1;
                    end
                    if (oresp.last) begin
                        state <= ST_IDLE;
                        ptr   <= next_idx(owner_q);
                        wdog  <= '0;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        // Counter parks at the limit; the lock is never aborted.
                        if (wdog >= WDOG_LIMIT) begin
                            err_timeout_q <= 1'b1;
                        end else begin
                            wdog <= wdog + WDOG_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign busy        = (state == ST_LOCKED);
    assign owner       = owner_q;
    assign err_timeout = err_timeout_q;
    assign err_drop    = err_drop_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb/tb_cbus_rr_arbiter.sv - self-checking bench for cbus_rr_arbiter
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int N3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    cbus_req_t  ireqs  [N];
    cbus_resp_t iresps [N];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;
    logic [1:0] owner;
    logic       err_timeout;
    logic       err_drop;

    cbus_req_t  ireqs3  [N3];
    cbus_resp_t iresps3 [N3];
    cbus_req_t  oreq3;
    cbus_resp_t oresp3;
    logic       busy3;
    logic [1:0] owner3;
    logic       err_timeout3;
    logic       err_drop3;

    cbus_rr_arbiter #(.NUM_INPUTS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps),
        .oreq(oreq), .oresp(oresp), .busy(busy), .owner(owner),
        .err_timeout(err_timeout), .err_drop(err_drop)
    );

    cbus_rr_arbiter #(.NUM_INPUTS(N3)) dut3 (
        .clk(clk), .resetn(resetn), .ireqs(ireqs3), .iresps(iresps3),
        .oreq(oreq3), .oresp(oresp3), .busy(busy3), .owner(owner3),
        .err_timeout(err_timeout3), .err_drop(err_drop3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic cbus_req_t mk_req(input int i, input logic v);
        cbus_req_t r;
        r        = '0;
        r.valid  = v;
        r.addr   = {24'hA00000, 8'(i)};
        r.data   = {24'h5A5A5A, 8'(i)};
        r.len    = 4'(i);
        r.strobe = 4'hF;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input logic [3:0] m);
        for (int i = 0; i < N; i++) ireqs[i] = mk_req(i, m[i]);
    endtask

    task automatic set_mask3(input logic [2:0] m);
        for (int i = 0; i < N3; i++) ireqs3[i] = mk_req(i, m[i]);
    endtask

    task automatic set_resp(input logic l);
        oresp.ready = 1'b1;
        oresp.last  = l;
        oresp.data  = $urandom;
        oresp3      = oresp;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_mask(4'b0000);
        set_mask3(3'b000);
        oresp  = '0;
        oresp3 = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [3:0] mask;
        logic       last;
        int         exp_grant;
        logic       exp_busy;
        int         exp_owner;
    } vec_t;

    vec_t vecs [12];

    int         m_ptr, m_owner, m_lockcyc;
    bit         m_locked, m_to, m_drop;
    int         g;
    cbus_req_t  exp_req;

    initial begin
        vecs[0]  = '{4'b0000, 1'b0, -1, 1'b0, 0};
        vecs[1]  = '{4'b0100, 1'b1,  2, 1'b0, 2};
        vecs[2]  = '{4'b1111, 1'b1,  3, 1'b0, 3};
        vecs[3]  = '{4'b1111, 1'b0,  0, 1'b1, 0};
        vecs[4]  = '{4'b1111, 1'b0,  0, 1'b1, 0};
        vecs[5]  = '{4'b1111, 1'b1,  0, 1'b0, 0};
        vecs[6]  = '{4'b1010, 1'b1,  1, 1'b0, 1};
        vecs[7]  = '{4'b1001, 1'b1,  3, 1'b0, 3};
        vecs[8]  = '{4'b0000, 1'b1, -1, 1'b0, 3};
        vecs[9]  = '{4'b0110, 1'b0,  1, 1'b1, 1};
        vecs[10] = '{4'b0110, 1'b1,  1, 1'b0, 1};
        vecs[11] = '{4'b0110, 1'b1,  2, 1'b0, 2};

        resetn = 1'b0;
        set_mask(4'b0000);
        set_mask3(3'b000);
        oresp  = '0;
        oresp3 = '0;
        #3;
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst owner", 128'(owner), 128'(0));
        chk("rst err_timeout", 128'(err_timeout), 128'(0));
        chk("rst err_drop", 128'(err_drop), 128'(0));
        chk("rst oreq", 128'(oreq), 128'(0));
        chk("rst iresps0", 128'(iresps[0]), 128'(0));
        do_reset();

        // Table-driven sequence from reset
        for (int v = 0; v < 12; v++) begin
            set_mask(vecs[v].mask);
            set_resp(vecs[v].last);
            #2;
            exp_req = (vecs[v].exp_grant < 0) ? '0 : mk_req(vecs[v].exp_grant, vecs[v].mask[vecs[v].exp_grant]);
            chk($sformatf("vec%0d oreq", v), 128'(oreq), 128'(exp_req));
            for (int i = 0; i < N; i++)
                chk($sformatf("vec%0d iresps%0d", v, i), 128'(iresps[i]),
                    (i == vecs[v].exp_grant) ? 128'(oresp) : 128'(0));
            tick();
            chk($sformatf("vec%0d busy", v), 128'(busy), 128'(vecs[v].exp_busy));
            chk($sformatf("vec%0d owner", v), 128'(owner), 128'(vecs[v].exp_owner));
        end

        // Fairness: four masters, 4-beat bursts
        do_reset();
        set_mask(4'b1111);
        for (int b = 0; b < 5; b++) begin
            set_resp(1'b0);
            #2;
            chk($sformatf("fair%0d grant busy", b), 128'(busy), 128'(0));
            chk($sformatf("fair%0d grant oreq", b), 128'(oreq), 128'(mk_req(b % 4, 1'b1)));
            tick();
            for (int beat = 2; beat <= 4; beat++) begin
                set_resp(beat == 4);
                #2;
                chk($sformatf("fair%0d beat%0d busy", b, beat), 128'(busy), 128'(1));
                chk($sformatf("fair%0d beat%0d owner", b, beat), 128'(owner), 128'(b % 4));
                tick();
            end
        end

        // Lock: master 1 burst of 8, master 0 requests from beat 3
        do_reset();
        set_mask(4'b0010);
        set_resp(1'b0);
        #2;
        chk("lock grant oreq", 128'(oreq), 128'(mk_req(1, 1'b1)));
        tick();
        for (int beat = 2; beat <= 8; beat++) begin
            if (beat >= 3) set_mask(4'b0011);
            set_resp(beat == 8);
            #2;
            chk($sformatf("lock beat%0d oreq", beat), 128'(oreq), 128'(mk_req(1, 1'b1)));
            chk($sformatf("lock beat%0d iresps0", beat), 128'(iresps[0]), 128'(0));
            tick();
        end
        set_mask(4'b0001);
        set_resp(1'b0);
        #2;
        chk("lock regrant busy", 128'(busy), 128'(0));
        chk("lock regrant oreq", 128'(oreq), 128'(mk_req(0, 1'b1)));
        chk("lock regrant iresps0", 128'(iresps[0]), 128'(oresp));
        tick();

        // Wrap with three inputs
        do_reset();
        set_mask3(3'b010);
        set_resp(1'b1);
        tick();
        set_mask3(3'b100);
        set_resp(1'b0);
        tick();
        chk("wrap3 locked busy", 128'(busy3), 128'(1));
        set_mask3(3'b101);
        set_resp(1'b1);
        tick();
        chk("wrap3 owner", 128'(owner3), 128'(2));
        set_resp(1'b1);
        #2;
        chk("wrap3 next grant", 128'(oreq3), 128'(mk_req(0, 1'b1)));
        tick();

        // Watchdog, dropped valid, asynchronous reset
        do_reset();
        set_mask(4'b1000);
        set_resp(1'b0);
        tick();
        for (int c = 1; c <= 16; c++) begin
            set_resp(1'b0);
            tick();
            if (c == 15) chk("wdog before limit", 128'(err_timeout), 128'(0));
        end
        chk("wdog at limit", 128'(err_timeout), 128'(1));
        chk("wdog busy held", 128'(busy), 128'(1));
        chk("drop before", 128'(err_drop), 128'(0));
        set_mask(4'b0000);
        tick();
        chk("drop flag", 128'(err_drop), 128'(1));
        chk("drop lock kept", 128'(busy), 128'(1));
        chk("drop owner", 128'(owner), 128'(3));
        #2;
        resetn = 1'b0;
        oresp  = '0;
        #1;
        chk("async busy", 128'(busy), 128'(0));
        chk("async owner", 128'(owner), 128'(0));
        chk("async err_timeout", 128'(err_timeout), 128'(0));
        chk("async err_drop", 128'(err_drop), 128'(0));
        chk("async oreq", 128'(oreq), 128'(0));
        tick();
        resetn = 1'b1;

        // Randomized run against a behavioural model
        do_reset();
        m_ptr = 0; m_owner = 0; m_lockcyc = 0;
        m_locked = 0; m_to = 0; m_drop = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (m_locked && i == m_owner) begin
                    if ($urandom_range(0, 63) == 0) ireqs[i].valid = 1'b0;
                end else begin
                    ireqs[i]          = mk_req(i, 1'($urandom_range(0, 1)));
                    ireqs[i].data     = $urandom;
                    ireqs[i].is_write = 1'($urandom_range(0, 1));
                end
            end
            oresp.ready = 1'($urandom_range(0, 1));
            oresp.last  = ($urandom_range(0, 2) == 0);
            oresp.data  = $urandom;
            #2;
            g = -1;
            if (m_locked) g = m_owner;
            else begin
                for (int k = 0; k < N; k++) begin
                    if (ireqs[(m_ptr + k) % N].valid) begin
                        g = (m_ptr + k) % N;
                        break;
                    end
                end
            end
            exp_req = (g < 0) ? '0 : ireqs[g];
            chk($sformatf("rnd%0d oreq", cyc), 128'(oreq), 128'(exp_req));
            for (int i = 0; i < N; i++)
                chk($sformatf("rnd%0d iresps%0d", cyc, i), 128'(iresps[i]),
                    (i == g) ? 128'(oresp) : 128'(0));
            if (m_locked) begin
                if (!ireqs[m_owner].valid) m_drop = 1;
                if (oresp.last) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % N;
                end else begin
                    m_lockcyc++;
                    if (m_lockcyc >= T) m_to = 1;
                end
            end else if (g >= 0) begin
                m_owner = g;
                if (oresp.last) m_ptr = (g + 1) % N;
                else begin
                    m_locked  = 1;
                    m_lockcyc = 0;
                end
            end
            tick();
            chk($sformatf("rnd%0d busy", cyc), 128'(busy), 128'(m_locked));
            chk($sformatf("rnd%0d owner", cyc), 128'(owner), 128'(m_owner));
            chk($sformatf("rnd%0d err_timeout", cyc), 128'(err_timeout), 128'(m_to));
            chk($sformatf("rnd%0d err_drop", cyc), 128'(err_drop), 128'(m_drop));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
